// File: rtl/button_conditioner_if.sv
// Button/paddle-control bundle between the raw paddle buttons and the button conditioner.
// The slave modport is the conditioner's view; the master modport is the driver/observer side.
interface button_conditioner_if;
    logic       i_btn1_left;
    logic       i_btn1_right;
    logic       i_btn2_left;
    logic       i_btn2_right;
    logic       o_control1_left;
    logic       o_control1_right;
    logic       o_control2_left;
    logic       o_control2_right;
    logic [3:0] o_press;

    modport slave (
        input  i_btn1_left,
        input  i_btn1_right,
        input  i_btn2_left,
        input  i_btn2_right,
        output o_control1_left,
        output o_control1_right,
        output o_control2_left,
        output o_control2_right,
        output o_press
    );

    modport master (
        output i_btn1_left,
        output i_btn1_right,
        output i_btn2_left,
        output i_btn2_right,
        input  o_control1_left,
        input  o_control1_right,
        input  o_control2_left,
        input  o_control2_right,
        input  o_press
    );
endinterface

// File: rtl/button_conditioner.sv
// Four-channel paddle button conditioner: 2-flop sync, counter debounce, press pulse, per-player conflict masking.
// Define BTN_ACTIVE_LOW_EN for pull-up buttons (raw 0 = pressed); default build treats raw inputs as active-high.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned CNT_W           = 17
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    button_conditioner_if.slave  btn
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order matches o_press: {2R, 2L, 1R, 1L}
    logic [3:0]       raw_w;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       stable_q;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       press_q;
    logic [3:0]       press_d;
    logic [3:0]       ctrl_q;
    logic [3:0]       ctrl_d;

`ifdef BTN_ACTIVE_LOW_EN
    assign raw_w = ~{btn.i_btn2_right, btn.i_btn2_left, btn.i_btn1_right, btn.i_btn1_left};
`else
    assign raw_w =  {btn.i_btn2_right, btn.i_btn2_left, btn.i_btn1_right, btn.i_btn1_left};
`endif

    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        // Outputs are derived from the next stable value so they register on the same edge as stable
        press_d   = stable_d & ~stable_q;
        ctrl_d[0] = stable_d[0] & ~stable_d[1];
        ctrl_d[1] = stable_d[1] & ~stable_d[0];
        ctrl_d[2] = stable_d[2] & ~stable_d[3];
        ctrl_d[3] = stable_d[3] & ~stable_d[2];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            press_q  <= '0;
            ctrl_q   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= raw_w;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            ctrl_q   <= ctrl_d;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn.o_control1_left  = ctrl_q[0];
    assign btn.o_control1_right = ctrl_q[1];
    assign btn.o_control2_left  = ctrl_q[2];
    assign btn.o_control2_right = ctrl_q[3];
    assign btn.o_press          = press_q;

endmodule
